// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame sequencer that serialises words MSB-first and counts PAT_W-bit pattern hits.
// Define SEQ_SCAN_OVERLAP_EN to count overlapping matches; the default build is non-overlapping.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              busy,
  output logic              done,
  output logic [7:0]        status_view
);

  // state | meaning
  // IDLE  | accepts pattern writes and start
  // LOAD  | word_ready high, waiting for the next word
  // SHIFT | one serial bit per cycle, pattern match running
  // DONE  | one-cycle frame-complete pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [PAT_W-1:0]  PAT_RST  = PAT_W'(8'h16);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PAT_W-1:0]    r_pattern;
  logic [WORD_W-1:0]   r_word;
  logic [IDX_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_remaining;
  logic [PAT_W-1:0]    r_window;
  logic [FILL_W-1:0]   r_fill;
  logic [CNT_W-1:0]    r_hit_count;
  logic                r_hit;

  logic                w_word_ready;
  logic                w_bit_valid;
  logic                w_done;
  logic [PAT_W-1:0]    w_win_next;
  logic [FILL_W-1:0]   w_fill_inc;
  logic                w_match;

  always_ff @(posedge fclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_word_ready = 1'b0;
    w_bit_valid  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (frame_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_word_ready = 1'b1;
        if (word_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_bit_valid = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = (r_remaining != '0) ? S_LOAD : S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The match uses the window as it will be after this bit shifts in.
  assign w_win_next = {r_window[PAT_W-2:0], r_word[WORD_W-1]};
  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
  assign w_match    = w_bit_valid && (r_fill >= FILL_ARM) && (w_win_next == r_pattern);

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      r_pattern   <= PAT_RST;
      r_word      <= '0;
      r_idx       <= '0;
      r_remaining <= '0;
      r_window    <= '0;
      r_fill      <= '0;
      r_hit_count <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_hit <= w_match;
      if (r_state == S_IDLE) begin
        if (cfg_we) r_pattern <= cfg_pattern;
        if (start) begin
          r_window    <= '0;
          r_fill      <= '0;
          r_hit_count <= '0;
          r_remaining <= frame_len;
        end
      end
      if (w_word_ready && word_valid) begin
        r_word      <= word_in;
        r_idx       <= '0;
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_bit_valid) begin
        r_word   <= {r_word[WORD_W-2:0], 1'b0};
        r_idx    <= r_idx + IDX_W'(1);
        r_window <= w_win_next;
`ifdef SEQ_SCAN_OVERLAP_EN
        r_fill   <= w_fill_inc;
`else
        r_fill   <= w_match ? '0 : w_fill_inc;
`endif
        if (w_match && (r_hit_count != CNT_MAX)) r_hit_count <= r_hit_count + CNT_W'(1);
      end
    end
  end

  assign word_ready  = w_word_ready;
  assign bit_valid   = w_bit_valid;
  assign bit_out     = w_bit_valid & r_word[WORD_W-1];
  assign hit         = r_hit;
  assign hit_count   = r_hit_count;
  assign busy        = (r_state != S_IDLE);
  assign done        = w_done;
  assign status_view = {6'b0, r_state};

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller for serial pattern detection. Accepts a frame of parallel words from an upstream producer over a ready/valid handshake and serialises each word MSB-first onto a bit stream. It runs a configurable PAT_W-bit pattern match over that stream, with matches spanning word boundaries, and reports per-hit pulses, a saturating hit count and frame completion. It sits between a word source and the status LEDs/display, and owns the sequencing the bare bit-level detector lacks.

## Interface
- WORD_W, 8, bits per input word, serialised MSB first
- PAT_W, 5, pattern length in bits, 2..8
- CNT_W, 8, hit counter width
- LEN_W, 4, frame length field width (words per frame)
- fclk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- cfg_we  in  1  pattern write strobe, honoured only in IDLE
- cfg_pattern  in  PAT_W  pattern, first bit in MSB
- start  in  1  begin frame, honoured only in IDLE
- frame_len  in  LEN_W  words in frame, sampled with start
- word_in  in  WORD_W  input word
- word_valid  in  1  word_in valid
- word_ready  out  1  controller can accept word_in
- bit_out  out  1  current serial bit
- bit_valid  out  1  bit_out meaningful (SHIFT state)
- hit  out  1  one-cycle match pulse
- hit_count  out  CNT_W  matches this frame, saturating
- busy  out  1  state != IDLE
- done  out  1  one-cycle frame-complete pulse
- status_view  out  8  {6'b0, state}; IDLE=0, LOAD=1, SHIFT=2, DONE=3

## Operation
- Registers: pattern (reset PAT_W'b10110 truncated/zero-extended from LSB), word shift reg, bit index, words remaining, window (PAT_W bits), fill count (0..PAT_W), hit_count.
- IDLE: cfg_we=1 loads cfg_pattern. start=1 clears window, fill, and hit_count, then loads remaining=frame_len. If frame_len==0, go to DONE, else go to LOAD. If start and cfg_we are both high, the pattern write happens first and the new pattern is used for the frame.
- LOAD: word_ready=1. On word_valid&&word_ready, capture word_in, set bit index=0, decrement remaining, and go to SHIFT. While word_valid=0, wait with no timeout.
- SHIFT: bit_valid=1, bit_out=word[WORD_W-1-idx]. Each cycle: window <= {window[PAT_W-2:0], bit_out} and fill <= min(fill+1, PAT_W). Match when (fill >= PAT_W-1) and the new window equals the pattern. On the last bit (idx==WORD_W-1), go to LOAD if remaining!=0, else go to DONE.
- Match: hit=1 next cycle; hit_count+1, holding at 2^CNT_W-1.
- DONE: done=1 for one cycle, then go to IDLE. hit_count holds until the next accepted start.
- cfg_we and start outside IDLE are ignored. Words are never accepted outside LOAD.
- Window and fill persist across word boundaries within a frame.

## Timing
- Reset (rst_n low at an edge) forces: state IDLE, word_ready 0, bit_out 0, bit_valid 0, hit 0, hit_count 0, busy 0, done 0, status_view 0, pattern 10110. Reset takes effect from any state, mid-frame included; the partial frame is discarded.
- start to word_ready: 1 cycle.
- Handshake cycle to first bit_valid: 1 cycle. SHIFT lasts exactly WORD_W cycles.
- Back-to-back words: minimum WORD_W+1 cycles per word.
- hit asserts the cycle after the bit_valid cycle that completes the match. hit_count updates in the same cycle as hit.
- done asserts the cycle after the last SHIFT cycle, or 1 cycle after start when frame_len=0. A hit from the final bit is coincident with done.

## Configuration
- SEQ_SCAN_OVERLAP_EN defined: overlapping matches are counted; window and fill are untouched on a match.
- Undefined: non-overlapping. On a match, fill is cleared to 0 in the same update, so the next match needs PAT_W fresh bits.

## Test plan
- Reset, pattern 10110, frame_len=1, word 0xB6 -> with OVERLAP_EN: 2 hit pulses (after bits 4 and 7), hit_count=2, done 1 cycle after the last bit. Without it: 1 hit, hit_count=1.
- frame_len=2, words 0x05 then 0x80 with a 3-cycle word_valid gap -> word_ready held through the gap, one cross-boundary hit after bit 1 of word 2, hit_count=1.
- frame_len=0 -> done pulses 1 cycle after start, hit_count=0, word_ready never high.
- cfg_we with pattern 11111 during SHIFT -> ignored, frame uses 10110. The same write in IDLE, then word 0xFF -> OVERLAP_EN: hit_count=4; without: 1.
- rst_n low for 1 cycle at SHIFT bit 3 -> next cycle IDLE, all outputs at reset values, pattern back to 10110.
- CNT_W=2, frame of three 0xFF words, pattern 11111, OVERLAP_EN -> hit_count saturates at 3, and hit keeps pulsing after saturation.
